// File: rtl/gpio_debounce.sv
// gpio_debounce: per-bit two-flop synchroniser followed by a hold-off
// debouncer. A level change on a pin is accepted only after the
// synchronised value has disagreed with the debounced level for H+1
// consecutive samples. Accepted changes produce registered rise/fall
// pulses and a combined change strobe.

// One input bit: synchroniser, hold-off counter, debounced level and
// edge pulses. o_event_nxt exposes the "change accepted this edge" term so
// the top level can register a combined strobe coincident with the pulses.
module gpio_debounce_bit #(
   parameter int   CW   = 16,
   parameter logic INIT = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_raw,
   input  logic [CW-1:0] i_holdoff,
   output logic          o_level,
   output logic          o_rise,
   output logic          o_fall,
   output logic          o_event_nxt
);

   logic          r_a;
   logic          r_s;
   logic          r_d;
   logic [CW-1:0] r_cnt;
   logic          r_rise;
   logic          r_fall;

   logic          w_diff;
   logic          w_expire;

   // The count is compared with >= so that lowering H below a running
   // count expires the bit on the very next edge. Because an expiry clears
   // the count, it never exceeds H and therefore cannot wrap, even when H
   // is all-ones.
   assign w_diff   = r_s ^ r_d;
   assign w_expire = w_diff && (r_cnt >= i_holdoff);

   // Synchroniser, hold-off counter, debounced level and edge pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a    <= INIT;
         r_s    <= INIT;
         r_d    <= INIT;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_a    <= i_raw;
         r_s    <= r_a;
         r_rise <= w_expire &  r_s;
         r_fall <= w_expire & ~r_s;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_expire) begin
            r_d   <= r_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign o_level     = r_d;
   assign o_rise      = r_rise;
   assign o_fall      = r_fall;
   assign o_event_nxt = w_expire;

endmodule

// Top level: an array of independent per-bit conditioners plus one
// registered OR strobe that is high whenever any bit rises or falls.
module gpio_debounce #(
   parameter int             NIN     = 16,
   parameter int             CW      = 16,
   parameter logic [NIN-1:0] INITIAL = {NIN{1'b0}}
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic [NIN-1:0] i_gpio_raw,
   input  logic [CW-1:0]  i_holdoff,
   output logic [NIN-1:0] o_gpio,
   output logic [NIN-1:0] o_rise,
   output logic [NIN-1:0] o_fall,
   output logic           o_changed
);

   logic [NIN-1:0] w_level;
   logic [NIN-1:0] w_rise;
   logic [NIN-1:0] w_fall;
   logic [NIN-1:0] w_event_nxt;
   logic           r_changed;

   for (genvar k = 0; k < NIN; k++) begin : g_bit
      gpio_debounce_bit #(
         .CW   (CW),
         .INIT (INITIAL[k])
      ) u_bit (
         .i_clk       (i_clk),
         .i_reset     (i_reset),
         .i_raw       (i_gpio_raw[k]),
         .i_holdoff   (i_holdoff),
         .o_level     (w_level[k]),
         .o_rise      (w_rise[k]),
         .o_fall      (w_fall[k]),
         .o_event_nxt (w_event_nxt[k])
      );
   end

   // Combined strobe, registered from the same terms as the per-bit pulses
   // so it lines up with them; simultaneous changes give a single pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_changed <= 1'b0;
      else         r_changed <= |w_event_nxt;
   end

   assign o_gpio    = w_level;
   assign o_rise    = w_rise;
   assign o_fall    = w_fall;
   assign o_changed = r_changed;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce with INITIAL=16'h0003.
module tb_gpio_debounce;

   logic        clk;
   logic        rst;
   logic [15:0] raw;
   logic [15:0] holdoff;
   logic [15:0] gpio;
   logic [15:0] rise;
   logic [15:0] fall;
   logic        changed;

   int errs   = 0;
   int checks = 0;

   gpio_debounce #(
      .NIN     (16),
      .CW      (16),
      .INITIAL (16'h0003)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_gpio_raw (raw),
      .i_holdoff  (holdoff),
      .o_gpio     (gpio),
      .o_rise     (rise),
      .o_fall     (fall),
      .o_changed  (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance n rising edges, then settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // full output snapshot against expected values
   task automatic chk_all(input string tag, input logic [15:0] eg, input logic [15:0] er,
                          input logic [15:0] ef, input logic ec);
      chk({tag, "_gpio"},    {16'h0, gpio},    {16'h0, eg});
      chk({tag, "_rise"},    {16'h0, rise},    {16'h0, er});
      chk({tag, "_fall"},    {16'h0, fall},    {16'h0, ef});
      chk({tag, "_changed"}, {31'h0, changed}, {31'h0, ec});
   endtask

   logic any_chg;

   initial begin
      rst     = 1'b1;
      raw     = 16'h0003;
      holdoff = 16'd3;

      // reset state, held and after release
      tick(3);
      chk_all("reset_held", 16'h0003, 16'h0, 16'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk_all("post_reset", 16'h0003, 16'h0, 16'h0, 1'b0);
      end

      // H=3 clean step on bit 4: sampled at edge t, visible at t+5
      raw = 16'h0013;
      tick(5);                               // edges t..t+4
      chk_all("step4_early", 16'h0003, 16'h0, 16'h0, 1'b0);
      tick(1);                               // edge t+5
      chk_all("step4_edge", 16'h0013, 16'h0010, 16'h0, 1'b1);
      tick(1);
      chk_all("step4_after", 16'h0013, 16'h0, 16'h0, 1'b0);

      // H=3, bit 5 high for only 3 samples: rejected
      raw = 16'h0033;
      tick(3);
      raw = 16'h0013;
      any_chg = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         any_chg |= changed;
      end
      chk("glitch3_gpio", {16'h0, gpio}, 32'h0013);
      chk("glitch3_nochg", {31'h0, any_chg}, 32'h0);

      // 4 samples high: accepted at t+5, then falls at t+9
      raw = 16'h0033;
      tick(4);                               // edges t..t+3
      raw = 16'h0013;
      tick(1);                               // t+4
      chk("pulse4_pre", {16'h0, gpio}, 32'h0013);
      tick(1);                               // t+5
      chk_all("pulse4_up", 16'h0033, 16'h0020, 16'h0, 1'b1);
      tick(3);                               // t+8
      chk_all("pulse4_hold", 16'h0033, 16'h0, 16'h0, 1'b0);
      tick(1);                               // t+9
      chk_all("pulse4_down", 16'h0013, 16'h0, 16'h0020, 1'b1);

      // H=0: simultaneous rise and fall across bits
      holdoff = 16'd0;
      raw     = 16'h00F3;
      tick(6);
      chk("h0_setup", {16'h0, gpio}, 32'h00F3);
      raw = 16'h0F03;
      tick(2);                               // edges t, t+1
      chk("h0_early", {16'h0, gpio}, 32'h00F3);
      tick(1);                               // t+2
      chk_all("h0_swap", 16'h0F03, 16'h0F00, 16'h00F0, 1'b1);
      tick(1);
      chk_all("h0_after", 16'h0F03, 16'h0, 16'h0, 1'b0);

      // H=10, bit 0 mismatched for 6 counts, then H lowered to 2
      holdoff = 16'd10;
      raw     = 16'h0F02;
      tick(8);                               // edges t..t+7, count now 6
      chk("lowh_pre", {16'h0, gpio}, 32'h0F03);
      holdoff = 16'd2;
      tick(1);
      chk_all("lowh_expire", 16'h0F02, 16'h0, 16'h0001, 1'b1);

      // restore bit 0, then reset mid-count abandons the transition
      raw = 16'h0F03;
      tick(6);
      chk("rst_setup", {16'h0, gpio}, 32'h0F03);
      holdoff = 16'd10;
      raw     = 16'h0F02;
      tick(8);
      chk("rst_pre", {16'h0, gpio}, 32'h0F03);
      rst = 1'b1;
      tick(1);
      chk_all("rst_mid", 16'h0003, 16'h0, 16'h0, 1'b0);
      raw = 16'h0003;
      tick(1);
      rst = 1'b0;
      any_chg = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         any_chg |= changed;
      end
      chk("rst_quiet_gpio", {16'h0, gpio}, 32'h0003);
      chk("rst_quiet_chg", {31'h0, any_chg}, 32'h0);

      // H=all-ones on bit 1: update exactly at t+2+65535, no wrap
      holdoff = 16'hFFFF;
      raw     = 16'h0001;
      any_chg = 1'b0;
      for (int i = 0; i < 65537; i++) begin  // edges t..t+65536
         tick(1);
         any_chg |= changed;
      end
      chk("hmax_pre_gpio", {16'h0, gpio}, 32'h0003);
      chk("hmax_pre_chg", {31'h0, any_chg}, 32'h0);
      tick(1);                               // t+65537
      chk_all("hmax_edge", 16'h0001, 16'h0, 16'h0002, 1'b1);
      tick(1);
      chk_all("hmax_after", 16'h0001, 16'h0, 16'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
